// File: rtl/slave_port_pkg.sv
// Shared definitions for the serial bus slave endpoint: state encodings,
// default widths and a counter-sizing helper.
package slave_port_pkg;

  localparam int DEF_ADDR_WIDTH   = 12;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_READ_LATENCY = 4;
  localparam int DEF_TIMEOUT      = 15;

  // Encodings are also decoded by the master-side interface block.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RLAT  = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    WDATA = ST_WDATA,
    WRITE = ST_WRITE,
    RLAT  = ST_RLAT,
    RDATA = ST_RDATA
  } state_e;

  // Bits needed for a counter that must hold the value n.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/slave_memory.sv
// Local storage for the slave: synchronous write port and a registered
// read port with one cycle of latency.
module slave_memory
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // NOTE: the array has no reset branch on purpose; contents survive reset
  // and a reset loop over every word would prevent RAM inference.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/slave_port.sv
// Serial bus slave endpoint: deserialises address/write data from the
// arbiter into local memory and serialises read data back.
module slave_port
  import slave_port_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY,
  parameter int TIMEOUT      = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic address,
  input  logic data,
  input  logic valid,
  input  logic write_en,
  output logic ready,
  output logic data_out,
  output logic valid_out
);

  localparam int MAX_BITS = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int BW = cnt_width(MAX_BITS);
  localparam int LW = cnt_width(READ_LATENCY);
  localparam int TW = cnt_width(TIMEOUT);

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]         lat_cnt_q, lat_cnt_d;
  logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rd_sr_q, rd_sr_d;
  logic                  ready_q, ready_d;
  logic                  valid_out_q, valid_out_d;
  logic                  data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Read address follows the next-state address so the registered read
  // already holds the final word during the first RLAT cycle.
  slave_memory #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (state_q == WRITE),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(addr_d),
    .rdata(mem_rdata)
  );

  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves
    // a signal unassigned and infers a latch.
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    lat_cnt_d = lat_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_sr_d   = rd_sr_q;

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          addr_d    = {addr_q[ADDR_WIDTH-2:0], address};
          we_d      = write_en;
          bit_cnt_d = BW'(1);
          tmo_cnt_d = '0;
          state_d   = ADDR;
        end
      end
      ADDR, WDATA: begin
        if (valid) begin
          tmo_cnt_d = '0;
          if (state_q == ADDR) begin
            addr_d = {addr_q[ADDR_WIDTH-2:0], address};
            if (bit_cnt_q == BW'(ADDR_WIDTH - 1)) begin
              bit_cnt_d = '0;
              lat_cnt_d = '0;
              state_d   = we_q ? WDATA : RLAT;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else begin
            wdata_d = {wdata_q[DATA_WIDTH-2:0], data};
            if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
              bit_cnt_d = '0;
              state_d   = WRITE;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          tmo_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      RLAT: begin
        if (lat_cnt_q == LW'(READ_LATENCY - 1)) begin
          rd_sr_d   = mem_rdata;
          bit_cnt_d = '0;
          state_d   = RDATA;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      RDATA: begin
        rd_sr_d = rd_sr_q << 1;
        if (bit_cnt_q == BW'(DATA_WIDTH - 1)) begin
          bit_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d     = !(state_d inside {WRITE, RLAT});
    valid_out_d = (state_d == RDATA);
    data_out_d  = (state_d == RDATA) & rd_sr_d[DATA_WIDTH-1];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_sr_q     <= '0;
      ready_q     <= 1'b1;
      valid_out_q <= 1'b0;
      data_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rd_sr_q     <= rd_sr_d;
      ready_q     <= ready_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
    end
  end

  assign ready     = ready_q;
  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;

endmodule
